// File: rtl/bp_me_pkg.sv
// Shared types for the BedRock stream arbitration blocks.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_idle,
    e_locked
  } bp_stream_arb_state_e;

endpackage

// File: rtl/bp_stream_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping at num_req_p.
module bp_stream_rr_pick
  import bp_me_pkg::*;
#(
  parameter int unsigned num_req_p  = 4,
  parameter int unsigned id_width_p = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]  req_i,
  input  logic [id_width_p-1:0] ptr_i,
  output logic [id_width_p-1:0] sel_o,
  output logic                  found_o
);

  localparam logic [id_width_p:0] NumReq = (id_width_p+1)'(num_req_p);

  // One spare bit so ptr + offset can be wrapped by compare-and-subtract for any num_req_p.
  logic [id_width_p:0] idx;

  always_comb begin
    sel_o   = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      idx = {1'b0, ptr_i} + (id_width_p+1)'(i);
      if (idx >= NumReq) begin
        idx = idx - NumReq;
      end
      if (!found_o && req_i[idx[id_width_p-1:0]]) begin
        found_o = 1'b1;
        sel_o   = idx[id_width_p-1:0];
      end
    end
  end

endmodule

// File: rtl/bp_stream_lock_arbiter.sv
// Per-message round-robin arbiter sharing one BedRock stream channel; the grant is held
// from the first locked beat until the unlocked last beat is accepted.
module bp_stream_lock_arbiter
  import bp_me_pkg::*;
#(
  parameter int unsigned num_req_p      = 4,
  parameter int unsigned header_width_p = 128,
  parameter int unsigned data_width_p   = 64
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_req_p*header_width_p-1:0] in_msg_header_i,
  input  logic [num_req_p*data_width_p-1:0]   in_msg_data_i,
  input  logic [num_req_p-1:0]                in_msg_v_i,
  output logic [num_req_p-1:0]                in_msg_ready_and_o,
  input  logic [num_req_p-1:0]                in_msg_lock_i,
  output logic [header_width_p-1:0]           out_msg_header_o,
  output logic [data_width_p-1:0]             out_msg_data_o,
  output logic                                out_msg_v_o,
  input  logic                                out_msg_ready_and_i,
  output logic                                out_msg_lock_o
);

  localparam int unsigned id_width_lp = $clog2(num_req_p);

  bp_stream_arb_state_e   state_q, state_d;
  logic [id_width_lp-1:0] gnt_id_q, gnt_id_d;
  logic [id_width_lp-1:0] rr_ptr_q, rr_ptr_d;

  logic [id_width_lp-1:0] pick_sel, sel;
  logic                   pick_found, has_gnt;
  logic [header_width_p-1:0] sel_header;
  logic [data_width_p-1:0]   sel_data;
  logic                      sel_v, sel_lock, fire;

  function automatic logic [id_width_lp-1:0] rr_inc(input logic [id_width_lp-1:0] id);
    return (id == id_width_lp'(num_req_p - 1)) ? '0 : id + id_width_lp'(1);
  endfunction

  bp_stream_rr_pick #(
    .num_req_p (num_req_p),
    .id_width_p(id_width_lp)
  ) u_pick (
    .req_i  (in_msg_v_i),
    .ptr_i  (rr_ptr_q),
    .sel_o  (pick_sel),
    .found_o(pick_found)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      e_idle: begin
        if (fire) begin
          if (sel_lock) begin
            state_d  = e_locked;
            gnt_id_d = sel;
          end else begin
            rr_ptr_d = rr_inc(sel);
          end
        end
      end
      e_locked: begin
        if (fire && !sel_lock) begin
          state_d  = e_idle;
          rr_ptr_d = rr_inc(gnt_id_q);
        end
      end
      default: state_d = e_idle;
    endcase
  end

  always_comb begin
    if (state_q == e_locked) begin
      sel     = gnt_id_q;
      has_gnt = 1'b1;
    end else begin
      sel     = pick_sel;
      has_gnt = pick_found;
    end

    sel_header = '0;
    sel_data   = '0;
    sel_v      = 1'b0;
    sel_lock   = 1'b0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (sel == id_width_lp'(i)) begin
        sel_header = in_msg_header_i[i*header_width_p +: header_width_p];
        sel_data   = in_msg_data_i[i*data_width_p +: data_width_p];
        sel_v      = in_msg_v_i[i];
        sel_lock   = in_msg_lock_i[i];
      end
    end

    // Outputs are forced quiet while reset is held, even with live requester inputs.
    out_msg_v_o      = has_gnt & sel_v & ~reset_i;
    out_msg_lock_o   = out_msg_v_o & sel_lock;
    out_msg_header_o = reset_i ? '0 : sel_header;
    out_msg_data_o   = reset_i ? '0 : sel_data;
    fire             = out_msg_v_o & out_msg_ready_and_i;

    // Ready follows the grant alone, so a locked owner in a bubble still sees ready.
    in_msg_ready_and_o = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      in_msg_ready_and_o[i] = has_gnt & ~reset_i & out_msg_ready_and_i &
                              (sel == id_width_lp'(i));
    end
  end

  ready_onehot0_a: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(in_msg_ready_and_o));

endmodule

// File: tb/tb_bp_stream_lock_arbiter.sv
// Directed bench for bp_stream_lock_arbiter with a beat scoreboard (4 requesters) and a
// small 3-requester instance for the non-power-of-two pointer wrap.
module tb_bp_stream_lock_arbiter;

  localparam int N  = 4;
  localparam int HW = 128;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*HW-1:0] hdr4;
  logic [N*DW-1:0] dat4;
  logic [N-1:0]    v4, lock4, rdy4;
  logic [HW-1:0]   ohdr4;
  logic [DW-1:0]   odat4;
  logic            ov4, olock4, ordy;

  logic [3*HW-1:0] hdr3;
  logic [3*DW-1:0] dat3;
  logic [2:0]      v3, lock3, rdy3;
  logic [HW-1:0]   ohdr3;
  logic [DW-1:0]   odat3;
  logic            ov3, olock3;

  bp_stream_lock_arbiter #(.num_req_p(4), .header_width_p(HW), .data_width_p(DW)) dut4 (
    .clk_i              (clk),
    .reset_i            (rst),
    .in_msg_header_i    (hdr4),
    .in_msg_data_i      (dat4),
    .in_msg_v_i         (v4),
    .in_msg_ready_and_o (rdy4),
    .in_msg_lock_i      (lock4),
    .out_msg_header_o   (ohdr4),
    .out_msg_data_o     (odat4),
    .out_msg_v_o        (ov4),
    .out_msg_ready_and_i(ordy),
    .out_msg_lock_o     (olock4)
  );

  bp_stream_lock_arbiter #(.num_req_p(3), .header_width_p(HW), .data_width_p(DW)) dut3 (
    .clk_i              (clk),
    .reset_i            (rst),
    .in_msg_header_i    (hdr3),
    .in_msg_data_i      (dat3),
    .in_msg_v_i         (v3),
    .in_msg_ready_and_o (rdy3),
    .in_msg_lock_i      (lock3),
    .out_msg_header_o   (ohdr3),
    .out_msg_data_o     (odat3),
    .out_msg_v_o        (ov3),
    .out_msg_ready_and_i(ordy),
    .out_msg_lock_o     (olock3)
  );

  int checks   = 0;
  int failures = 0;

  // Requester models: remaining beats, beat index, message count, reload count, bubble hold.
  int rem[N], bidx[N], mcnt[N], msgs_left[N], nb[N], exp_mcnt[N];
  bit hold[N];
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int id, input int m, input int b);
    return {40'h0, id[7:0], m[7:0], b[7:0]};
  endfunction

  // Header: msg_type in [127:120], addr in [63:0] with a 6-bit beat offset at the bottom.
  function automatic logic [127:0] beat_hdr(input int id, input int m, input int b);
    return {id[7:0], 56'h0, 42'h0, id[7:0], m[7:0], b[5:0]};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      v4[i]              = (rem[i] > 0) && !hold[i];
      lock4[i]           = rem[i] > 1;
      dat4[i*DW +: DW]   = beat_data(i, mcnt[i], bidx[i]);
      hdr4[i*HW +: HW]   = beat_hdr(i, mcnt[i], bidx[i]);
    end
  endtask

  task automatic cycle();
    logic [N-1:0] fired;
    @(negedge clk);
    fired = v4 & rdy4;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        bidx[i]++;
        rem[i]--;
        if (rem[i] == 0) begin
          mcnt[i]++;
          bidx[i] = 0;
          if (msgs_left[i] > 0) begin
            rem[i] = nb[i];
            msgs_left[i]--;
          end
        end
      end
    end
    drive();
  endtask

  task automatic expect_msg(input int id, input int nbeats);
    for (int b = 0; b < nbeats; b++) exp_q.push_back(beat_data(id, exp_mcnt[id], b));
    exp_mcnt[id]++;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    chk(tag, 128'(exp_q.size()), 128'd0);
  endtask

  // Scoreboard monitor: every accepted output beat must be the next expected one.
  logic [7:0]  prev_type;
  logic [57:0] prev_addr_hi;
  bit          prev_locked = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_locked = 1'b0;
    end else if (ov4 && ordy) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 128'(exp_q.size()), 128'd1);
      end else begin
        chk("sb_beat", 128'(odat4), 128'(exp_q.pop_front()));
      end
      if (prev_locked) begin
        chk("hdr_type_stable", 128'(ohdr4[127:120]), 128'(prev_type));
        chk("hdr_addr_stable", 128'(ohdr4[63:6]), 128'(prev_addr_hi));
      end
      prev_type    = ohdr4[127:120];
      prev_addr_hi = ohdr4[63:6];
      prev_locked  = olock4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    ordy = 1'b0;
    hdr3 = '0;
    dat3 = '0;
    v3   = '0;
    lock3 = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 1; bidx[i] = 0; mcnt[i] = 0; msgs_left[i] = 0; nb[i] = 0;
      exp_mcnt[i] = 0; hold[i] = 1'b0;
    end
    drive();
    ordy = 1'b1;
    #12;
    // Reset with every requester valid: everything must be quiet.
    chk("rst_v", 128'(ov4), 128'd0);
    chk("rst_rdy", 128'(rdy4), 128'd0);
    chk("rst_lock", 128'(olock4), 128'd0);
    chk("rst_hdr", ohdr4, 128'd0);
    chk("rst_data", 128'(odat4), 128'd0);
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("idle_v", 128'(ov4), 128'd0);
    chk("idle_rdy", 128'(rdy4), 128'd0);
    cycle();

    // Single beat from req2, visible the same cycle.
    rem[2] = 1;
    drive();
    #1;
    chk("single_v", 128'(ov4), 128'd1);
    chk("single_rdy", 128'(rdy4), 128'b0100);
    expect_msg(2, 1);
    drain("single_drain", 5);

    // Pointer now 3: req3 beats req1.
    rem[1] = 1;
    rem[3] = 1;
    drive();
    #1;
    chk("ptr3_rdy", 128'(rdy4), 128'b1000);
    expect_msg(3, 1);
    expect_msg(1, 1);
    drain("ptr3_drain", 10);

    // Pointer 2: req0 4-beat locked burst against a waiting req1.
    rem[0] = 4;
    rem[1] = 1;
    drive();
    expect_msg(0, 4);
    expect_msg(1, 1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("burst_rdy", 128'(rdy4), 128'b0001);
      cycle();
    end
    #1;
    chk("burst_next_rdy", 128'(rdy4), 128'b0010);
    drain("burst_drain", 5);

    // Fairness from a fresh pointer: continuous 2-beat messages from everyone.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 2; nb[i] = 2; msgs_left[i] = 1;
    end
    drive();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) expect_msg(i, 2);
    drain("fair_drain", 40);

    // Backpressure and bubble during a req1 burst while req2 waits.
    rem[1] = 4;
    rem[2] = 1;
    drive();
    expect_msg(1, 4);
    expect_msg(2, 1);
    cycle();
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy", 128'(rdy4), 128'd0);
      chk("bp_v", 128'(ov4), 128'd1);
      cycle();
    end
    ordy    = 1'b1;
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bubble_v", 128'(ov4), 128'd0);
      chk("bubble_rdy", 128'(rdy4), 128'b0010);
      cycle();
    end
    hold[1] = 1'b0;
    drive();
    drain("bp_drain", 10);

    // Async reset between beat 2 and beat 3 of a req3 burst.
    rem[3] = 4;
    drive();
    exp_q.push_back(beat_data(3, exp_mcnt[3], 0));
    exp_q.push_back(beat_data(3, exp_mcnt[3], 1));
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_v", 128'(ov4), 128'd0);
    chk("midrst_lock", 128'(olock4), 128'd0);
    chk("midrst_rdy", 128'(rdy4), 128'd0);
    chk("midrst_data", 128'(odat4), 128'd0);
    rem[3]  = 0;
    bidx[3] = 0;
    rem[0]  = 1;
    rem[1]  = 1;
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("postrst_rdy", 128'(rdy4), 128'b0001);
    chk("postrst_data", 128'(odat4), 128'(beat_data(0, mcnt[0], 0)));
    expect_msg(0, 1);
    expect_msg(1, 1);
    drain("postrst_drain", 10);

    // Three requesters: req1 (ptr->2), then req2 over req1 (ptr wraps to 0), then req0.
    for (int i = 0; i < 3; i++) begin
      dat3[i*DW +: DW] = beat_data(i, 1, 0);
      hdr3[i*HW +: HW] = beat_hdr(i, 1, 0);
    end
    v3 = 3'b010;
    #1;
    chk("n3_pick1", 128'(rdy3), 128'b010);
    @(posedge clk);
    #1 v3 = 3'b110;
    #1;
    chk("n3_pick2", 128'(rdy3), 128'b100);
    @(posedge clk);
    #1 v3 = 3'b011;
    #1;
    chk("n3_wrap_rdy", 128'(rdy3), 128'b001);
    chk("n3_wrap_data", 128'(odat3), 128'(beat_data(0, 1, 0)));
    @(posedge clk);
    #1 v3 = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_stream_lock_arbiter.md
Name: bp_stream_lock_arbiter

Overview:
- Round-robin arbiter that shares one BedRock stream channel among num_req_p stream masters, such as several lite-to-stream converters feeding one memory or I/O link.
- Arbitrates per message, not per beat. Once a requester's beat is accepted with lock asserted, the grant stays with that requester until its final (unlocked) beat is accepted. Beats of different messages are never interleaved.
- The output carries a lock signal so this block can be cascaded with further arbiters.

Parameters:
- num_req_p, 4, number of requesting stream masters (>=2).
- header_width_p, 128, width of one message header in bits.
- data_width_p, 64, width of one stream data beat in bits.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- in_msg_header_i  in  num_req_p*header_width_p  per-requester headers; requester i occupies slice [i*header_width_p +: header_width_p].
- in_msg_data_i  in  num_req_p*data_width_p  per-requester data beats, sliced the same way.
- in_msg_v_i  in  num_req_p  per-requester beat valid.
- in_msg_ready_and_o  out  num_req_p  per-requester ready (ready-valid-and); at most one bit is set at a time.
- in_msg_lock_i  in  num_req_p  per-requester lock: more beats of this message follow the current beat.
- out_msg_header_o  out  header_width_p  header of the granted requester.
- out_msg_data_o  out  data_width_p  data of the granted requester.
- out_msg_v_o  out  1  output beat valid.
- out_msg_ready_and_i  in  1  downstream ready.
- out_msg_lock_o  out  1  granted requester's lock, gated by out_msg_v_o.

Behaviour:
- Registered state:
  - state: e_idle or e_locked.
  - gnt_id_r: the held grant, clog2(num_req_p) bits.
  - rr_ptr_r: highest-priority index, clog2(num_req_p) bits.
- Reset (asynchronous, immediate): state=e_idle, gnt_id_r=0, rr_ptr_r=0. While reset_i=1, all outputs are 0: out_msg_v_o, out_msg_lock_o, in_msg_ready_and_o, header and data.
- Reset mid-message: any lock in progress is abandoned. After reset there is no stale grant.
- Grant selection in e_idle:
  - sel = the first i with in_msg_v_i[i]=1, scanning rr_ptr_r, rr_ptr_r+1, ... modulo num_req_p.
  - If no requester is valid, there is no grant and out_msg_v_o=0.
- Grant selection in e_locked: sel = gnt_id_r, regardless of any other valids.
- Datapath, zero latency and purely combinational:
  - out_msg_header_o, out_msg_data_o and the lock = slice sel.
  - out_msg_v_o = in_msg_v_i[sel], with a grant existing.
  - in_msg_ready_and_o = one-hot(sel) & {num_req_p{out_msg_ready_and_i}}.
  - Ready does not depend on the requester's own valid beyond the selection itself.
- Handshake: fire = out_msg_v_o & out_msg_ready_and_i. Only a fire advances state.
- State transitions:
  - e_idle, fire with lock=1 -> e_locked; gnt_id_r <= sel; rr_ptr_r unchanged.
  - e_idle, fire with lock=0 (single-beat message) -> stay e_idle; rr_ptr_r <= sel+1 mod num_req_p.
  - e_locked, fire with lock=1 -> stay.
  - e_locked, fire with lock=0 (last beat) -> e_idle; rr_ptr_r <= gnt_id_r+1 mod num_req_p.
  - No fire -> hold all state.
- Bubbles: if the locked requester drops valid mid-message, out_msg_v_o=0. The grant is held, and other requesters see ready=0 indefinitely.
- rr_ptr wrap: num_req_p-1 wraps to 0. For non-power-of-two num_req_p, the increment is an explicit compare-and-wrap, not a natural overflow.
- Simultaneous events:
  - A new requester raising valid in the same cycle as a last-beat fire is considered only from the next cycle.
  - Downstream ready with no valid changes nothing.
- Fairness: with all requesters continuously valid, each gets exactly one message per num_req_p messages.
- Assertions (simulation only):
  - in_msg_ready_and_o is one-hot0.
  - In e_locked, out_msg_header_o's msg_type and addr-above-beat-offset are unchanged across beats. The header format is known only to the bench.

Decomposition:
- Shared package bp_me_pkg holds the state typedef bp_stream_arb_state_e (e_idle, e_locked).
- The priority pick is one natural sub-module, bp_stream_rr_pick. It is combinational: it takes a request vector and rr_ptr and returns sel and a found flag.
- State, pointer and muxing live in the top.

Test Plan:
- Reset, then single beat: num_req_p=4, only req2 valid, lock=0, downstream ready -> out_msg_v_o=1 the same cycle; in_msg_ready_and_o=4'b0100; rr_ptr_r becomes 3.
- Locked burst vs. contention: req0 sends 4 beats (lock 1,1,1,0) while req1 is continuously valid -> 4 consecutive req0 beats, req1 ready=0 throughout, then req1 granted on the next cycle.
- Fairness: all 4 requesters send continuous 2-beat messages -> output grant order is 0,0,1,1,2,2,3,3,0,0…
- Backpressure and bubble: out_msg_ready_and_i=0 for 3 cycles mid-burst, and the owner drops valid 2 cycles -> no beat is lost or duplicated, no other requester is granted, and the sequence completes in order.
- Async reset mid-burst: assert reset_i between beat 2 and beat 3 of req3 -> all outputs are 0 immediately; after release, state is e_idle, rr_ptr_r=0, and req0 wins over valid req1.
- Wrap and non-power-of-two: num_req_p=3, req2 single beat -> rr_ptr_r=0; next, with req0 and req1 both valid, req0 is granted.
